// File: rtl/dcache_refill_ctl.sv
// Data-cache refill/writeback engine: streams a dirty victim line out, reads the
// new line in word by word, then pulses a one-cycle response with the assembled line.
module dcache_refill_ctl #(
   parameter int unsigned LINE_WORDS = 16,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_miss_req,
   input  logic [ADDR_W-1:0]          i_miss_addr,
   input  logic                       i_wb_dirty,
   input  logic [ADDR_W-1:0]          i_wb_addr,
   input  logic [32*LINE_WORDS-1:0]   i_wb_line,
   output logic [32*LINE_WORDS-1:0]   o_memory_line,
   output logic                       o_memory_response,
   output logic                       o_busy,
   output logic                       o_mem_req,
   output logic                       o_mem_we,
   output logic [ADDR_W-1:0]          o_mem_addr,
   output logic [31:0]                o_mem_wdata,
   input  logic                       i_mem_ready,
   input  logic [31:0]                i_mem_rdata
);

   localparam int unsigned       CNT_W     = $clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0]  LAST      = CNT_W'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {IDLE, WB, RD, RESP} state_t;

   state_t                      state, state_nxt;
   logic [CNT_W-1:0]            cnt;
   logic [ADDR_W-1:0]           miss_base, wb_base;
   logic [ADDR_W-1:0]           beat_off;
   logic [LINE_WORDS-1:0][31:0] wb_words;
   logic [LINE_WORDS-1:0][31:0] line_words;
   logic                        beat_done;

   assign beat_off      = ADDR_W'({cnt, 2'b00});
   assign o_memory_line = line_words;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt         = state;
      o_busy            = 1'b0;
      o_mem_req         = 1'b0;
      o_mem_we          = 1'b0;
      o_mem_addr        = '0;
      o_mem_wdata       = '0;
      o_memory_response = 1'b0;
      beat_done         = 1'b0;
      case (state)
         IDLE: begin
            if (i_miss_req) state_nxt = i_wb_dirty ? WB : RD;
         end
         WB: begin
            o_busy      = 1'b1;
            o_mem_req   = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = wb_base + beat_off;
            o_mem_wdata = wb_words[cnt];
            beat_done   = i_mem_ready;
            if (i_mem_ready && cnt == LAST) state_nxt = RD;
         end
         RD: begin
            o_busy     = 1'b1;
            o_mem_req  = 1'b1;
            o_mem_addr = miss_base + beat_off;
            beat_done  = i_mem_ready;
            if (i_mem_ready && cnt == LAST) state_nxt = RESP;
         end
         RESP: begin
            o_busy            = 1'b1;
            o_memory_response = 1'b1;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are captured only in IDLE; later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         miss_base  <= '0;
         wb_base    <= '0;
         wb_words   <= '0;
         line_words <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_miss_req) begin
                  miss_base <= i_miss_addr & LINE_MASK;
                  wb_base   <= i_wb_addr & LINE_MASK;
                  wb_words  <= i_wb_line;
                  cnt       <= '0;
               end
            end
            WB, RD: begin
               if (beat_done) begin
                  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                  if (state == RD) line_words[cnt] <= i_mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_refill_ctl.sv
// Randomized bench for dcache_refill_ctl: a transaction-level model predicts every
// beat, the returned line and the response timing; a 4-word instance covers small lines.
module tb_dcache_refill_ctl;

   localparam int unsigned LW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              miss_req, wb_dirty, mem_ready;
   logic [31:0]       miss_addr, wb_addr, mem_rdata;
   logic [LW*32-1:0]  wb_line, memory_line;
   logic              memory_response, busy, mem_req, mem_we;
   logic [31:0]       mem_addr, mem_wdata;

   logic              miss_req4, wb_dirty4, mem_ready4;
   logic [31:0]       miss_addr4, wb_addr4, mem_rdata4;
   logic [127:0]      wb_line4, memory_line4;
   logic              memory_response4, busy4, mem_req4, mem_we4;
   logic [31:0]       mem_addr4, mem_wdata4;

   dcache_refill_ctl #(.LINE_WORDS(16), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_miss_req(miss_req), .i_miss_addr(miss_addr), .i_wb_dirty(wb_dirty),
      .i_wb_addr(wb_addr), .i_wb_line(wb_line),
      .o_memory_line(memory_line), .o_memory_response(memory_response), .o_busy(busy),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
   );

   dcache_refill_ctl #(.LINE_WORDS(4), .ADDR_W(32)) dut4 (
      .clk(clk), .rst(rst),
      .i_miss_req(miss_req4), .i_miss_addr(miss_addr4), .i_wb_dirty(wb_dirty4),
      .i_wb_addr(wb_addr4), .i_wb_line(wb_line4),
      .o_memory_line(memory_line4), .o_memory_response(memory_response4), .o_busy(busy4),
      .o_mem_req(mem_req4), .o_mem_we(mem_we4), .o_mem_addr(mem_addr4), .o_mem_wdata(mem_wdata4),
      .i_mem_ready(mem_ready4), .i_mem_rdata(mem_rdata4)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW*32-1:0] rand_line();
      logic [LW*32-1:0] l;
      for (int k = 0; k < LW; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   // One miss: entered at a negedge with the engine idle. mode 0 = ready always,
   // 1 = ready pattern 1,0,0 repeating, 2 = random ready. abort_at >= 0 resets at that read beat.
   task automatic run_miss(input bit dirty, input logic [31:0] maddr, input logic [31:0] waddr,
                           input logic [LW*32-1:0] vline, input logic [LW*32-1:0] rline,
                           input int mode, input bit drop_req, input int abort_at, input int exp_lat);
      logic [31:0] mbase, wbase;
      int nwb, total, b, c, stalls;
      bit rdy, done;
      mbase = {maddr[31:6], 6'b0};
      wbase = {waddr[31:6], 6'b0};
      nwb   = dirty ? LW : 0;
      total = nwb + LW;
      miss_req = 1'b1; miss_addr = maddr; wb_addr = waddr; wb_dirty = dirty; wb_line = vline;
      @(posedge clk);
      b = 0; c = 0; stalls = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         c++;
         miss_addr = $urandom; wb_addr = $urandom; wb_dirty = 1'($urandom); wb_line = rand_line();
         if (drop_req) miss_req = 1'b0;
         if (c > 4 * total + 8) begin
            check("timeout", 0, 1);
            done = 1;
         end else if (b < total) begin
            check("busy", busy, 1);
            check("mem_req", mem_req, 1);
            check("early_resp", memory_response, 0);
            if (b < nwb) begin
               check("we_wr", mem_we, 1);
               check("wr_addr", mem_addr, wbase + 32'(4 * b));
               check("wdata", mem_wdata, vline[b*32 +: 32]);
            end else begin
               check("we_rd", mem_we, 0);
               check("rd_addr", mem_addr, mbase + 32'(4 * (b - nwb)));
            end
            if (abort_at >= 0 && b == nwb + abort_at) begin
               rst = 1'b1; miss_req = 1'b0;
               #1;
               check("abort_busy", busy, 0);
               check("abort_req", mem_req, 0);
               check("abort_line", memory_line, '0);
               check("abort_resp", memory_response, 0);
               @(negedge clk);
               rst = 1'b0;
               @(negedge clk);
               check("post_abort_busy", busy, 0);
               check("post_abort_resp", memory_response, 0);
               check("post_abort_req", mem_req, 0);
               return;
            end
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (c % 3) == 1;
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            mem_ready = rdy;
            mem_rdata = (b >= nwb) ? rline[(b - nwb)*32 +: 32] : $urandom;
            if (rdy) b++;
            else     stalls++;
         end else begin
            mem_ready = 1'($urandom);
            check("resp", memory_response, 1);
            check("resp_busy", busy, 1);
            check("resp_req", mem_req, 0);
            check("line", memory_line, rline);
            check("latency", c, (exp_lat > 0) ? exp_lat : total + stalls + 1);
            done = 1;
         end
      end
   endtask

   // Called in the response cycle: one cycle later the engine must be idle even if
   // the request is still held; the line must persist.
   task automatic finish_gap(input bit hold, input logic [LW*32-1:0] exp_line);
      miss_req = hold;
      @(negedge clk);
      check("gap_busy", busy, 0);
      check("gap_resp", memory_response, 0);
      check("gap_req", mem_req, 0);
      check("gap_line", memory_line, exp_line);
   endtask

   logic [LW*32-1:0] vl, rl;
   logic [127:0]     rl4;
   bit               hold;

   initial begin
      rst = 1'b1;
      miss_req = 0; miss_addr = '0; wb_dirty = 0; wb_addr = '0; wb_line = '0;
      mem_ready = 0; mem_rdata = '0;
      miss_req4 = 0; miss_addr4 = '0; wb_dirty4 = 0; wb_addr4 = '0; wb_line4 = '0;
      mem_ready4 = 0; mem_rdata4 = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_resp", memory_response, 0);
      check("rst_line", memory_line, '0);
      check("rst_busy4", busy4, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // clean miss, fixed data pattern
      for (int k = 0; k < LW; k++) rl[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      run_miss(0, 32'h0000_1044, 32'h0, '0, rl, 0, 0, -1, 17);
      finish_gap(0, rl);

      // dirty miss
      for (int k = 0; k < LW; k++) vl[k*32 +: 32] = 32'hB0 + 32'(k);
      rl = rand_line();
      run_miss(1, 32'h0000_3000, 32'h0000_2000, vl, rl, 0, 0, -1, 33);
      finish_gap(0, rl);

      // backpressure on a dirty miss, request dropped mid-transfer
      vl = rand_line(); rl = rand_line();
      run_miss(1, $urandom, $urandom, vl, rl, 1, 1, -1, 0);
      finish_gap(0, rl);

      // reset at read beat 7, then a clean miss
      run_miss(0, $urandom, $urandom, rand_line(), rand_line(), 0, 0, 7, 0);
      rl = rand_line();
      run_miss(0, $urandom, $urandom, rand_line(), rl, 0, 0, -1, 17);
      finish_gap(0, rl);

      // top-of-address-space line, then back-to-back request held through RESP
      rl = rand_line();
      run_miss(0, 32'hFFFF_FFC0, 32'h0, '0, rl, 0, 0, -1, 17);
      check("wrap_last_addr", {32'hFFFF_FFC0} + 32'(4 * (LW - 1)), 32'hFFFF_FFFC);
      finish_gap(1, rl);
      rl = rand_line();
      run_miss(1, $urandom, $urandom, rand_line(), rl, 0, 0, -1, 33);

      // randomized traffic
      for (int t = 0; t < 10; t++) begin
         hold = 1'($urandom);
         finish_gap(hold, rl);
         rl = rand_line();
         run_miss(1'($urandom), $urandom, $urandom, rand_line(), rl, 2, 1'($urandom), -1, 0);
      end
      finish_gap(0, rl);

      // 4-word line instance: clean miss
      for (int k = 0; k < 4; k++) rl4[k*32 +: 32] = $urandom;
      miss_req4 = 1'b1; miss_addr4 = 32'h0000_5678; wb_dirty4 = 1'b0; mem_ready4 = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         miss_req4 = 1'b0;
         if (c <= 4) begin
            check("l4_req", mem_req4, 1);
            check("l4_we", mem_we4, 0);
            check("l4_addr", mem_addr4, 32'h0000_5670 + 32'(4 * (c - 1)));
            check("l4_early_resp", memory_response4, 0);
            mem_rdata4 = rl4[(c-1)*32 +: 32];
         end else begin
            check("l4_resp", memory_response4, 1);
            check("l4_line", memory_line4, rl4);
         end
      end
      @(negedge clk);
      check("l4_idle", busy4, 0);
      check("l4_resp_end", memory_response4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
